// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts a program image over valid/ready, holds the CPU
// in reset until the image is complete, then serves combinational word fetches.
module imem_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Load_Start,
    input  logic [ADDR_W:0]   Load_Count,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [31:0]       Fetch_Addr,
    output logic [DATA_W-1:0] Instr,
    output logic              Cpu_Reset,
    output logic              Load_Busy,
    output logic              Load_Done,
    output logic              Load_Err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [CNT_W-1:0]    remaining_q;
    logic [CNT_W-1:0]    remaining_d;
    logic                xfer_c;
    logic                count_ok_c;
    logic [ADDR_W-1:0]   rd_idx_c;
    logic                unused_fetch_bits;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign xfer_c      = (state_q == LOAD) && In_Valid;
    assign count_ok_c  = (Load_Count != '0) && (Load_Count <= CNT_W'(DEPTH));
    assign wr_addr_d   = wr_addr_q + ADDR_W'(1);
    assign remaining_d = remaining_q - CNT_W'(1);

    // Load sequencing; a full-depth load lets wr_addr wrap to 0 as it leaves LOAD.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (In_Valid) begin
                        wr_addr_q   <= wr_addr_d;
                        remaining_q <= remaining_d;
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                default: begin
                    if (Load_Start) begin
                        if (count_ok_c) begin
                            state_q     <= LOAD;
                            wr_addr_q   <= '0;
                            remaining_q <= Load_Count;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
            endcase
        end
    end

    // Program storage is never cleared; words past the image keep old contents.
    always_ff @(posedge Clk) begin
        if (!Reset && xfer_c) begin
            mem_q[wr_addr_q] <= In_Data;
        end
    end

    assign In_Ready  = (state_q == LOAD);
    assign Load_Busy = (state_q == LOAD);
    assign Load_Done = (state_q == DONE);
    assign Load_Err  = (state_q == ERR);
    assign Cpu_Reset = (state_q != DONE);

    // Word-aligned fetch; byte offset and high address bits are don't-care.
    assign rd_idx_c          = Fetch_Addr[ADDR_W+1:2];
    assign unused_fetch_bits = ^{Fetch_Addr[31:ADDR_W+2], Fetch_Addr[1:0]};
    assign Instr             = (state_q == DONE) ? mem_q[rd_idx_c] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: default-size instance plus a 16-word
// instance for full-depth and address-wrap checks.
module tb_imem_loader;

    logic        Clk = 1'b0;
    logic        Reset;

    logic        a_start;
    logic [10:0] a_count;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_fetch;
    logic [31:0] a_instr;
    logic        a_cpu_rst;
    logic        a_busy;
    logic        a_done;
    logic        a_err;

    logic        b_start;
    logic [4:0]  b_count;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_fetch;
    logic [31:0] b_instr;
    logic        b_cpu_rst;
    logic        b_busy;
    logic        b_done;
    logic        b_err;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    imem_loader #(.ADDR_W(10), .DATA_W(32)) u_dut_a (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load_Start (a_start),
        .Load_Count (a_count),
        .In_Data    (a_data),
        .In_Valid   (a_valid),
        .In_Ready   (a_ready),
        .Fetch_Addr (a_fetch),
        .Instr      (a_instr),
        .Cpu_Reset  (a_cpu_rst),
        .Load_Busy  (a_busy),
        .Load_Done  (a_done),
        .Load_Err   (a_err)
    );

    imem_loader #(.ADDR_W(4), .DATA_W(32)) u_dut_b (
        .Clk        (Clk),
        .Reset      (Reset),
        .Load_Start (b_start),
        .Load_Count (b_count),
        .In_Data    (b_data),
        .In_Valid   (b_valid),
        .In_Ready   (b_ready),
        .Fetch_Addr (b_fetch),
        .Instr      (b_instr),
        .Cpu_Reset  (b_cpu_rst),
        .Load_Busy  (b_busy),
        .Load_Done  (b_done),
        .Load_Err   (b_err)
    );

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'hFFFF_FFFC;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checks++;
        if (a_cpu_rst !== 1'b1 || a_ready !== 1'b0 || a_done !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: cpu_rst=%b ready=%b done=%b busy=%b err=%b, required 1 0 0 0 0",
                     a_cpu_rst, a_ready, a_done, a_busy, a_err);
        end
        checks++;
        if (b_cpu_rst !== 1'b1 || b_ready !== 1'b0 || b_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_b: cpu_rst=%b ready=%b done=%b, required 1 0 0", b_cpu_rst, b_ready, b_done);
        end
        for (int i = 0; i < 3; i++) begin
            a_fetch = addrs[i];
            #1;
            checks++;
            if (a_instr !== 32'h0) begin
                errors++;
                $display("FAIL reset_instr: addr=%h instr=%h, required 0", addrs[i], a_instr);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        @(negedge Clk);
        a_start = 1'b1; a_count = 11'd4; a_valid = 1'b1; a_data = w[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            a_start = 1'b0;
            a_data  = w[i];
            checks++;
            if (a_ready !== 1'b1 || a_done !== 1'b0 || a_cpu_rst !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: beat=%0d ready=%b done=%b cpu_rst=%b, required 1 0 1", i, a_ready, a_done, a_cpu_rst);
            end
        end
        @(negedge Clk);
        a_valid = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_cpu_rst !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b cpu_rst=%b ready=%b, required 1 0 0", a_done, a_cpu_rst, a_ready);
        end
        for (int i = 0; i < 4; i++) begin
            a_fetch = 32'(i * 4);
            #1;
            checks++;
            if (a_instr !== w[i]) begin
                errors++;
                $display("FAIL b2b_fetch: addr=%h instr=%h, required %h", a_fetch, a_instr, w[i]);
            end
        end
        a_fetch = 32'd5;
        #1;
        checks++;
        if (a_instr !== 32'h22) begin
            errors++;
            $display("FAIL b2b_unaligned: addr=5 instr=%h, required 00000022", a_instr);
        end
    endtask

    task automatic test_valid_gaps();
        logic        pat  [5];
        logic [31:0] dat  [5];
        logic [31:0] exp_mem [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0; pat[4] = 1'b1;
        dat[0] = 32'hA1; dat[1] = 32'hDEAD; dat[2] = 32'hA2; dat[3] = 32'hBEEF; dat[4] = 32'hA3;
        exp_mem[0] = 32'hA1; exp_mem[1] = 32'hA2; exp_mem[2] = 32'hA3; exp_mem[3] = 32'h44;
        @(negedge Clk);
        a_start = 1'b1; a_count = 11'd3; a_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            a_start = 1'b0;
            a_valid = pat[k];
            a_data  = dat[k];
        end
        @(negedge Clk);
        checks++;
        if (a_done !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL gaps_done: done=%b ready=%b, required 1 0", a_done, a_ready);
        end
        a_valid = 1'b1;
        a_data  = 32'h0BAD;
        @(negedge Clk);
        a_valid = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL gaps_extra_valid: done=%b ready=%b, required 1 0", a_done, a_ready);
        end
        for (int i = 0; i < 4; i++) begin
            a_fetch = 32'(i * 4);
            #1;
            checks++;
            if (a_instr !== exp_mem[i]) begin
                errors++;
                $display("FAIL gaps_fetch: addr=%h instr=%h, required %h", a_fetch, a_instr, exp_mem[i]);
            end
        end
    endtask

    task automatic test_bad_count();
        @(negedge Clk);
        a_start = 1'b1; a_count = 11'd0;
        @(negedge Clk);
        a_start = 1'b0;
        checks++;
        if (a_err !== 1'b1 || a_cpu_rst !== 1'b1 || a_ready !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL bad_count_zero: err=%b cpu_rst=%b ready=%b done=%b, required 1 1 0 0", a_err, a_cpu_rst, a_ready, a_done);
        end
        a_start = 1'b1; a_count = 11'd2; a_valid = 1'b1; a_data = 32'h55;
        @(negedge Clk);
        a_start = 1'b0;
        checks++;
        if (a_err !== 1'b0 || a_ready !== 1'b1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL bad_count_recover: err=%b ready=%b busy=%b, required 0 1 1", a_err, a_ready, a_busy);
        end
        @(negedge Clk);
        a_data = 32'h66;
        @(negedge Clk);
        a_valid = 1'b0;
        a_fetch = 32'h4;
        #1;
        checks++;
        if (a_done !== 1'b1 || a_instr !== 32'h66) begin
            errors++;
            $display("FAIL bad_count_load2: done=%b instr=%h, required 1 00000066", a_done, a_instr);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w [4];
        w[0] = 32'h81; w[1] = 32'h82; w[2] = 32'h83; w[3] = 32'h84;
        @(negedge Clk);
        a_start = 1'b1; a_count = 11'd4; a_valid = 1'b1; a_data = 32'h71;
        @(negedge Clk);
        a_start = 1'b0;
        checks++;
        if (a_cpu_rst !== 1'b1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_cpu_rst: cpu_rst=%b busy=%b, required 1 1", a_cpu_rst, a_busy);
        end
        @(negedge Clk);
        a_data = 32'h72;
        @(negedge Clk);
        a_valid = 1'b0;
        Reset   = 1'b1;
        @(negedge Clk);
        Reset   = 1'b0;
        a_fetch = 32'h0;
        #1;
        checks++;
        if (a_cpu_rst !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0 || a_instr !== 32'h0) begin
            errors++;
            $display("FAIL midload_reset: cpu_rst=%b busy=%b ready=%b instr=%h, required 1 0 0 0",
                     a_cpu_rst, a_busy, a_ready, a_instr);
        end
        a_start = 1'b1; a_count = 11'd4; a_valid = 1'b1; a_data = w[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            a_start = (i == 2);
            a_count = (i == 2) ? 11'd1 : 11'd4;
            a_data  = w[i];
            if (i == 3) begin
                checks++;
                if (a_busy !== 1'b1 || a_err !== 1'b0 || a_done !== 1'b0) begin
                    errors++;
                    $display("FAIL midload_start_ignored: busy=%b err=%b done=%b, required 1 0 0", a_busy, a_err, a_done);
                end
            end
        end
        @(negedge Clk);
        a_start = 1'b0;
        a_valid = 1'b0;
        checks++;
        if (a_done !== 1'b1 || a_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL reload_done: done=%b cpu_rst=%b, required 1 0", a_done, a_cpu_rst);
        end
        for (int i = 0; i < 4; i++) begin
            a_fetch = 32'(i * 4);
            #1;
            checks++;
            if (a_instr !== w[i]) begin
                errors++;
                $display("FAIL reload_fetch: addr=%h instr=%h, required %h", a_fetch, a_instr, w[i]);
            end
        end
    endtask

    task automatic test_full_depth();
        logic [31:0] faddr [3];
        logic [31:0] fexp  [3];
        faddr[0] = 32'h40; fexp[0] = 32'h100;
        faddr[1] = 32'h3C; fexp[1] = 32'h10F;
        faddr[2] = 32'h7E; fexp[2] = 32'h10F;
        @(negedge Clk);
        b_start = 1'b1; b_count = 5'd17;
        @(negedge Clk);
        b_start = 1'b0;
        checks++;
        if (b_err !== 1'b1 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL full_over_count: err=%b busy=%b, required 1 0", b_err, b_busy);
        end
        b_start = 1'b1; b_count = 5'd16; b_valid = 1'b1; b_data = 32'h100;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            b_start = 1'b0;
            b_data  = 32'h100 + 32'(i);
            checks++;
            if (b_ready !== 1'b1 || b_done !== 1'b0) begin
                errors++;
                $display("FAIL full_ready: beat=%0d ready=%b done=%b, required 1 0", i, b_ready, b_done);
            end
        end
        @(negedge Clk);
        b_valid = 1'b0;
        checks++;
        if (b_done !== 1'b1 || b_ready !== 1'b0 || b_cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL full_done: done=%b ready=%b cpu_rst=%b, required 1 0 0", b_done, b_ready, b_cpu_rst);
        end
        for (int i = 0; i < 3; i++) begin
            b_fetch = faddr[i];
            #1;
            checks++;
            if (b_instr !== fexp[i]) begin
                errors++;
                $display("FAIL full_wrap_fetch: addr=%h instr=%h, required %h", faddr[i], b_instr, fexp[i]);
            end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        a_start = 1'b0; a_count = '0; a_data = '0; a_valid = 1'b0; a_fetch = '0;
        b_start = 1'b0; b_count = '0; b_data = '0; b_valid = 1'b0; b_fetch = '0;
        test_reset();
        test_back_to_back();
        test_valid_gaps();
        test_bad_count();
        test_reset_mid_load();
        test_full_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
